// File: rtl/adapter_from_bus_pkg.sv
// Shared rulec constants and types for the bus/message adapters.
package adapter_from_bus_pkg;

   localparam int BEAT_WIDTH   = 32;
   localparam int WORD_BEATS   = 4;
   localparam int LENGTH_WIDTH = 16;
   localparam int WORD_WIDTH   = BEAT_WIDTH * WORD_BEATS;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // One assembled message as exchanged with the downstream adapter.
   // The length field holds the beat count minus one.
   typedef struct packed {
      logic [WORD_WIDTH-1:0]   v;
      logic [LENGTH_WIDTH-1:0] length;
   } message_t;

endpackage

// File: rtl/adapter_from_bus.sv
// adapter_from_bus: packs a last-terminated stream of beats, little-end-first,
// into one message word with a beats-minus-one length field.
// Optional feature: define ADAPTER_FROM_BUS_ERR_EN to add a sticky 'err'
// output flagging dropped beats and length saturation.
module adapter_from_bus
  import adapter_from_bus_pkg::*;
#(
  parameter int BEAT_WIDTH = adapter_from_bus_pkg::BEAT_WIDTH,
  parameter int WORD_BEATS = adapter_from_bus_pkg::WORD_BEATS
)(
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             in_enq__ENA,
  input  logic [BEAT_WIDTH-1:0]            in_enq_v,
  input  logic                             in_enq_last,
  output logic                             in_enq__RDY,
  output logic                             out_enq__ENA,
  output logic [BEAT_WIDTH*WORD_BEATS-1:0] out_enq_v,
  output logic [LENGTH_WIDTH-1:0]          out_enq_length,
`ifdef ADAPTER_FROM_BUS_ERR_EN
  output logic                             err,
`endif
  input  logic                             out_enq__RDY
);

  localparam int WW = BEAT_WIDTH * WORD_BEATS;
  localparam int SW = (WORD_BEATS > 1) ? $clog2(WORD_BEATS) : 1;
  localparam logic [LENGTH_WIDTH-1:0] BEATS_L = LENGTH_WIDTH'(WORD_BEATS);
  localparam logic [LENGTH_WIDTH-1:0] CNT_MAX = '1;

  state_t                  state, state_nxt;
  logic [LENGTH_WIDTH-1:0] count;
  logic [LENGTH_WIDTH-1:0] length_q;
  logic [WW-1:0]           buffer;
  logic                    beat_xfer;
  logic                    msg_xfer;

  assign in_enq__RDY  = (state == FILL);
  assign out_enq__ENA = (state == HOLD);
  assign beat_xfer    = in_enq__ENA & in_enq__RDY;
  assign msg_xfer     = out_enq__ENA & out_enq__RDY;

  assign out_enq_v      = buffer;
  assign out_enq_length = length_q;

  always_ff @(posedge CLK) begin
    if (!nRST) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (beat_xfer && in_enq_last) state_nxt = HOLD;
      HOLD: if (msg_xfer)                 state_nxt = FILL;
      default:                            state_nxt = FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      buffer   <= '0;
      count    <= '0;
      length_q <= '0;
    end else if (msg_xfer) begin
      buffer <= '0;
      count  <= '0;
    end else if (beat_xfer) begin
      if (count < BEATS_L)
        buffer[BEAT_WIDTH*count[SW-1:0] +: BEAT_WIDTH] <= in_enq_v;
      if (count != CNT_MAX)
        count <= count + 1'b1;
      if (in_enq_last)
        length_q <= count;
    end
  end

`ifdef ADAPTER_FROM_BUS_ERR_EN
  always_ff @(posedge CLK) begin
    if (!nRST)
      err <= 1'b0;
    else if (beat_xfer && ((count >= BEATS_L) || (count == CNT_MAX - 1'b1)))
      err <= 1'b1;
  end
`endif

endmodule

// File: doc/adapter_from_bus.md
# adapter_from_bus

Bus-to-message packer sitting directly upstream of the message-to-bus adapter in the rulec datapath. It accepts a stream of 32-bit beats terminated by a `last` flag, assembles them little-end-first into one 128-bit message word, and emits that word with a length field in the same beats-minus-one encoding the downstream adapter consumes. Round trip is exact: packer → unpacker reproduces the original beat stream for messages of 1–4 beats.

## Interface
Parameters:
- BEAT_WIDTH, 32, width of one bus beat.
- WORD_BEATS, 4, beats per message word; word width = BEAT_WIDTH*WORD_BEATS (128).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- nRST  input  1  reset, synchronous, active-low.
- in$enq__ENA  input  1  beat valid.
- in$enq$v  input  32  beat data.
- in$enq$last  input  1  final beat of message.
- in$enq__RDY  output  1  packer can accept a beat.
- out$enq__ENA  output  1  assembled message valid.
- out$enq$v  output  128  message word; beat k in bits [32k+31:32k].
- out$enq$length  output  16  beat count minus one.
- out$enq__RDY  input  1  downstream accepts message.

## Operation
- State machine: FILL (accepting beats), HOLD (presenting message). Reset → FILL.
- in$enq__RDY = (state == FILL). out$enq__ENA = (state == HOLD). No combinational path from out$enq__RDY to in$enq__RDY.
- Beat transfer = in$enq__ENA & in$enq__RDY. On transfer in FILL:
  - if count < WORD_BEATS: buffer[32*count +: 32] ← v; else data discarded.
  - count ← count + 1, saturating at 16'hFFFF.
  - if last: state ← HOLD; length register ← count (the pre-increment value, i.e. beats − 1).
- Message transfer = out$enq__ENA & out$enq__RDY. On transfer in HOLD: state ← FILL, buffer ← 0, count ← 0.
- Unwritten slots of out$enq$v read zero, because the buffer is cleared on every message transfer and at reset.
- Beats beyond WORD_BEATS are counted but dropped. This matches the downstream adapter, which shifts zeros out past 128 bits.
- ENA asserted while RDY is low: no state change, no effect.
- Length saturation: a message of ≥ 65536 beats reports 16'hFFFF.

## Timing
- Reset values: in$enq__RDY=1, out$enq__ENA=0, out$enq$v=0, out$enq$length=0; count=0, state FILL.
- Latency: out$enq__ENA rises the cycle after the `last` beat transfers.
- out$enq$v and out$enq$length are registered and stable throughout HOLD.
- Throughput: N beats + 1 hold cycle minimum per message. in$enq__RDY returns high the cycle after message transfer.
- Reset asserted mid-message or in HOLD: partial/held message discarded, all state returns to reset values on that edge.

## Configuration
- ADAPTER_FROM_BUS_ERR_EN defined:
  - adds output `err` (1 bit, reset 0).
  - `err` is set sticky when a beat arrives with count ≥ WORD_BEATS, or when count saturates.
  - `err` is cleared only by reset.
- Undefined: no `err` port; overflow is silently truncated as described above.

## Structure
- Shared rulec package holds:
  - BEAT_WIDTH, WORD_BEATS, LENGTH_WIDTH(16) constants.
  - state enum {FILL, HOLD}.
  - message typedef {v[127:0], length[15:0]}, shared with the downstream adapter.
- No sub-module. Slot write decode is a single indexed part-select on the low bits of count.

## Test plan
- Single-beat message: v=32'hA5A5A5A5, last=1 → next cycle out$enq__ENA=1, v=128'h0…0A5A5A5A5, length=0.
- Four beats 1,2,3,4 (last on 4) → v=128'h00000004_00000003_00000002_00000001, length=3. Loopback through downstream adapter yields beats 1,2,3,4 with last on beat 4.
- Six beats 1..6 → v holds beats 1..4, length=5. With ADAPTER_FROM_BUS_ERR_EN, err=1 after beat 5.
- Backpressure: hold out$enq__RDY=0 for 10 cycles after message → in$enq__RDY=0 and outputs stable throughout. Beat offered during hold is not consumed. After RDY=1 for one cycle, a 2-beat message packs as v=128'h0…_00000008_00000007 with upper bits zero.
- nRST low after two beats of a four-beat message → all outputs at reset values. Next message 9 (last) → v=9, length=0.
